// File: rtl/mac_feeder.sv
// Operand feeder for an external multiply-accumulate unit: clears the MAC, streams len
// A/B pairs into it, then captures and holds the accumulated dot product until it is taken.
module mac_feeder #(
   parameter int DW = 8,
   parameter int RW = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [7:0]    len,
   input  logic          a_valid,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   input  logic [DW-1:0] b_data,
   output logic          a_ready,
   output logic          b_ready,
   output logic          En,
   output logic          Clr,
   output logic [DW-1:0] Ain,
   output logic [DW-1:0] Bin,
   input  logic [RW-1:0] Cout,
   output logic          busy,
   output logic          res_valid,
   output logic [RW-1:0] res_data,
   input  logic          res_ready
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_FEED  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [7:0]    count_q, count_d;
   logic [7:0]    len_q, len_d;
   logic          drain_q, drain_d;
   logic          en_q, en_d;
   logic [DW-1:0] ain_q, ain_d;
   logic [DW-1:0] bin_q, bin_d;
   logic          res_valid_q, res_valid_d;
   logic [RW-1:0] res_data_q, res_data_d;

   logic          feed_ready;
   logic          consume;
   logic [7:0]    count_inc;

   assign feed_ready = (state_q == ST_FEED) && (count_q < len_q);
   assign consume    = feed_ready && a_valid && b_valid;
   assign count_inc  = count_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      len_d       = len_q;
      drain_d     = drain_q;
      en_d        = 1'b0;
      ain_d       = ain_q;
      bin_d       = bin_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;

      case (state_q)
         ST_IDLE: begin
            if (start && (len != 8'd0)) begin
               len_d   = len;
               count_d = 8'd0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            state_d = ST_FEED;
         end
         ST_FEED: begin
            if (consume) begin
               en_d    = 1'b1;
               ain_d   = a_data;
               bin_d   = b_data;
               count_d = count_inc;
               if (count_inc == len_q) begin
                  drain_d = 1'b0;
                  state_d = ST_DRAIN;
               end
            end
         end
         // First DRAIN cycle carries the final En; the second waits for the MAC register.
         ST_DRAIN: begin
            if (!drain_q) begin
               drain_d = 1'b1;
            end else begin
               drain_d     = 1'b0;
               res_data_d  = Cout;
               res_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= 8'd0;
         len_q       <= 8'd0;
         drain_q     <= 1'b0;
         en_q        <= 1'b0;
         ain_q       <= '0;
         bin_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         len_q       <= len_d;
         drain_q     <= drain_d;
         en_q        <= en_d;
         ain_q       <= ain_d;
         bin_q       <= bin_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign a_ready   = feed_ready;
   assign b_ready   = feed_ready;
   assign Clr       = (state_q == ST_CLEAR);
   assign En        = en_q;
   assign Ain       = ain_q;
   assign Bin       = bin_q;
   assign busy      = (state_q != ST_IDLE);
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Randomized bench for mac_feeder: a behavioural MAC plus a dot-product reference computed
// directly from the operand lists, with a negedge protocol monitor.
module tb_mac_feeder;

   localparam int DW = 8;
   localparam int RW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    len;
   logic          a_valid;
   logic [DW-1:0] a_data;
   logic          b_valid;
   logic [DW-1:0] b_data;
   logic          a_ready;
   logic          b_ready;
   logic          En;
   logic          Clr;
   logic [DW-1:0] Ain;
   logic [DW-1:0] Bin;
   logic [RW-1:0] Cout;
   logic          busy;
   logic          res_valid;
   logic [RW-1:0] res_data;
   logic          res_ready;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] opA [256];
   logic [DW-1:0] opB [256];

   mac_feeder #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
      .a_ready(a_ready), .b_ready(b_ready), .En(En), .Clr(Clr),
      .Ain(Ain), .Bin(Bin), .Cout(Cout), .busy(busy),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
   );

   always #5 clk = ~clk;

   // External MAC: deliberately not reset, so a missing Clr shows up as a stale sum.
   logic [2*DW-1:0] macProd;
   assign macProd = Ain * Bin;
   initial Cout = '0;
   always @(posedge clk) begin
      if (Clr)
         Cout <= '0;
      else if (En)
         Cout <= Cout + RW'(macProd);
   end

   // Protocol monitor: counters are cumulative and only written here; jobs compare deltas.
   bit            monActive = 1'b0;
   bit            consumePrev = 1'b0;
   bit            resPrev = 1'b0;
   bit            consumeNow;
   logic [DW-1:0] expAin = '0;
   logic [DW-1:0] expBin = '0;
   int cyc = 0;
   int clrCnt = 0, enCnt = 0, orderBad = 0, enBad = 0, dataBad = 0, bothBad = 0, readyBad = 0;
   int riseCyc = 0, lastConsumeCyc = 0;

   always @(negedge clk) begin
      if (monActive) begin
         consumeNow = a_valid && b_valid && a_ready && !rst;
         if (En !== consumePrev) enBad++;
         if (Ain !== expAin || Bin !== expBin) dataBad++;
         if (Clr && En) bothBad++;
         if (b_ready !== a_ready) readyBad++;
         if (Clr && a_ready) readyBad++;
         if (Clr) clrCnt++;
         if (En) begin
            enCnt++;
            if (clrCnt == 0) orderBad++;
         end
         if (res_valid && !resPrev) riseCyc = cyc;
         if (consumeNow) lastConsumeCyc = cyc;
         if (rst) begin
            expAin = '0;
            expBin = '0;
         end else if (consumeNow) begin
            expAin = a_data;
            expBin = b_data;
         end
         consumePrev = consumeNow;
         resPrev     = res_valid;
      end
      cyc++;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one job over opA/opB[0..n-1]; mode 0 = always valid, 1 = random valids,
   // 2 = A-only stall for 5 ready cycles first. abortAfter>0 resets after that many pairs.
   task automatic applyStimulus(input int n, input int mode, input int hold,
                                input bit injectStart, input int abortAfter);
      longint expSum = 0;
      int idx = 0;
      int guard = 0;
      int stallLeft = (mode == 2) ? 5 : 0;
      bit injected = 1'b0;
      bit fire;
      int clrBase = clrCnt, enBase = enCnt, orderBase = orderBad, enBadBase = enBad;
      int dataBase = dataBad, bothBase = bothBad, readyBase = readyBad;
      int holdBad = 0;
      logic [RW-1:0] holdData;

      for (int i = 0; i < n; i++) expSum += longint'(opA[i]) * longint'(opB[i]);

      start = 1'b1;
      len   = 8'(n);
      @(posedge clk); #1;
      start = 1'b0;
      len   = 8'hAA;
      checkOutput("busy_after_start", busy, 1);
      checkOutput("clr_in_clear", Clr, 1);

      while (idx < n && guard < 4000) begin
         guard++;
         if (mode == 2 && stallLeft > 0) begin
            a_valid = 1'b1;
            b_valid = 1'b0;
            if (a_ready) stallLeft--;
         end else if (mode == 1) begin
            a_valid = ($urandom_range(0, 3) != 0);
            b_valid = ($urandom_range(0, 3) != 0);
         end else begin
            a_valid = 1'b1;
            b_valid = 1'b1;
         end
         a_data = opA[idx];
         b_data = opB[idx];
         if (injectStart && !injected && idx == 1) begin
            start    = 1'b1;
            len      = 8'd9;
            injected = 1'b1;
         end
         fire = a_valid && b_valid && a_ready;
         @(posedge clk); #1;
         start = 1'b0;
         if (fire) begin
            idx++;
            if (abortAfter > 0 && idx == abortAfter) break;
         end
      end
      a_valid = 1'b0;
      b_valid = 1'b0;

      if (abortAfter > 0) begin
         checkOutput("abort_fed", idx, abortAfter);
         rst = 1'b1;
         @(posedge clk); #1;
         checkOutput("abort_busy", busy, 0);
         checkOutput("abort_en", En, 0);
         checkOutput("abort_clr", Clr, 0);
         checkOutput("abort_ready", {a_ready, b_ready}, 0);
         checkOutput("abort_res", {res_valid, res_data}, 0);
         checkOutput("abort_ops", {Ain, Bin}, 0);
         rst = 1'b0;
         for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (res_valid || busy) holdBad++;
         end
         checkOutput("abort_no_result", holdBad, 0);
      end else begin
         checkOutput("feed_done", idx, n);
         guard = 0;
         while (!res_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
         end
         checkOutput("res_valid_seen", res_valid, 1);
         checkOutput("res_data", res_data, 64'(expSum[RW-1:0]));
         @(negedge clk); #1;
         checkOutput("res_latency", riseCyc - lastConsumeCyc, 3);
         checkOutput("clr_pulses", clrCnt - clrBase, 1);
         checkOutput("en_pulses", enCnt - enBase, n);
         checkOutput("clr_before_en", orderBad - orderBase, 0);
         checkOutput("en_follows_consume", enBad - enBadBase, 0);
         checkOutput("ain_bin_track", dataBad - dataBase, 0);
         checkOutput("clr_en_exclusive", bothBad - bothBase, 0);
         checkOutput("ready_rules", readyBad - readyBase, 0);

         holdData  = res_data;
         res_ready = 1'b0;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!res_valid || res_data !== holdData) holdBad++;
         end
         checkOutput("hold_stable", holdBad, 0);
         res_ready = 1'b1;
         @(posedge clk); #1;
         res_ready = 1'b0;
         checkOutput("handshake_valid", res_valid, 0);
         checkOutput("handshake_busy", busy, 0);
      end
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; len = 8'd0;
      a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      monActive = 1'b1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_ready", {a_ready, b_ready}, 0);
      checkOutput("rst_en_clr", {En, Clr}, 0);
      checkOutput("rst_res_valid", res_valid, 0);
      checkOutput("rst_res_data", res_data, 0);
      checkOutput("rst_ops", {Ain, Bin}, 0);
      rst = 1'b0;

      $display("[TB] start with len=0 in IDLE");
      start = 1'b1; len = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("len0_busy", busy, 0);
      checkOutput("len0_clr", Clr, 0);

      $display("[TB] basic job with 10-cycle result hold");
      opA[0] = 1; opA[1] = 2; opA[2] = 3;
      opB[0] = 4; opB[1] = 5; opB[2] = 6;
      applyStimulus(3, 0, 10, 1'b0, 0);
      checkOutput("basic_const", res_data, 32);

      $display("[TB] back-to-back job");
      opA[0] = 7; opA[1] = 1;
      opB[0] = 3; opB[1] = 9;
      applyStimulus(2, 0, 0, 1'b0, 0);

      $display("[TB] backpressure job");
      opA[0] = 1; opA[1] = 2; opA[2] = 3;
      opB[0] = 4; opB[1] = 5; opB[2] = 6;
      applyStimulus(3, 2, 1, 1'b0, 0);

      $display("[TB] start during FEED");
      opA[3] = 10; opB[3] = 11;
      applyStimulus(4, 0, 0, 1'b1, 0);

      $display("[TB] reset mid-job");
      applyStimulus(4, 0, 0, 1'b0, 2);
      opA[0] = 2; opB[0] = 3;
      applyStimulus(1, 0, 0, 1'b0, 0);

      $display("[TB] maximum job");
      for (int i = 0; i < 255; i++) begin
         opA[i] = 8'hFF;
         opB[i] = 8'hFF;
      end
      applyStimulus(255, 0, 0, 1'b0, 0);
      checkOutput("max_const", res_data, 24'hFD02FF);

      $display("[TB] random jobs");
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) begin
            opA[i] = DW'($urandom);
            opB[i] = DW'($urandom);
         end
         applyStimulus(n, 1, $urandom_range(0, 4), r[0], 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 SHALL have parameter DW, default 8, giving the operand width fed to the MAC.
REQ-002 SHALL have parameter RW, default 24, giving the MAC result width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  job request pulse.
REQ-006 SHALL have port len  input  8  dot-product length, sampled on an accepted start.
REQ-007 SHALL have port a_valid  input  1  A operand valid.
REQ-008 SHALL have port a_data  input  DW  A operand, unsigned.
REQ-009 SHALL have port b_valid  input  1  B operand valid.
REQ-010 SHALL have port b_data  input  DW  B operand, unsigned.
REQ-011 SHALL have port a_ready  output  1  A operand consumed when a_valid&b_valid&a_ready.
REQ-012 SHALL have port b_ready  output  1  equal to a_ready at all times.
REQ-013 SHALL have port En  output  1  MAC accumulate enable.
REQ-014 SHALL have port Clr  output  1  MAC accumulator clear.
REQ-015 SHALL have port Ain  output  DW  MAC A operand.
REQ-016 SHALL have port Bin  output  DW  MAC B operand.
REQ-017 SHALL have port Cout  input  RW  MAC accumulator value; registered, updated one edge after En.
REQ-018 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-019 SHALL have port res_valid  output  1  result valid.
REQ-020 SHALL have port res_data  output  RW  captured dot product.
REQ-021 SHALL have port res_ready  input  1  result consumer ready.

Function
REQ-022 SHALL implement the FSM states IDLE, CLEAR, FEED, DRAIN and HOLD.
REQ-023 In IDLE, start=1 with len!=0 SHALL latch len, zero the pair counter and go to CLEAR.
REQ-024 In IDLE, start with len==0 SHALL be ignored, leaving the block in IDLE.
REQ-025 start SHALL be ignored in every state other than IDLE.
REQ-026 CLEAR SHALL last exactly one cycle, with Clr=1 and En=0 in that cycle, and then go to FEED.
REQ-027 In FEED, a_ready/b_ready SHALL be 1 while count<len and 0 otherwise.
REQ-028 a_ready/b_ready SHALL be 0 in all states other than FEED.
REQ-029 A pair SHALL be consumed only when a_valid, b_valid and ready are all 1 in the same cycle.
REQ-030 One valid input without the other SHALL consume nothing.
REQ-031 En, Ain and Bin SHALL be registered: a consume at edge E SHALL give En=1 and Ain/Bin equal to the consumed data during cycle E..E+1.
REQ-032 En SHALL be 0 in every cycle that does not follow a consume.
REQ-033 Ain and Bin SHALL hold their last values when En=0.
REQ-034 A consume SHALL increment count by 1.
REQ-035 The consume that makes count==len SHALL move the FSM to DRAIN.
REQ-036 DRAIN SHALL last 2 cycles: the final En cycle, then one wait cycle while the MAC registers its result.
REQ-037 On the DRAIN exit edge, the block SHALL copy Cout into res_data, set res_valid=1 and go to HOLD.
REQ-038 res_valid SHALL therefore rise 2 edges after the final consume edge.
REQ-039 In HOLD, res_valid and res_data SHALL stay stable until res_valid&res_ready.
REQ-040 On the res_valid&res_ready edge, the block SHALL clear res_valid and return to IDLE.
REQ-041 A new start SHALL be accepted no earlier than the cycle after the HOLD handshake.
REQ-042 len=255 with DW=8 and all operands 255 SHALL give a result of 16,581,375, which fits in 24 bits; no saturation or overflow logic is required.
REQ-043 Clr and En SHALL never both be 1 in the same cycle.

Reset
REQ-044 rst=1 at a clock edge SHALL force IDLE and clear count, latched len, En, Clr, Ain, Bin, res_valid and res_data to 0.
REQ-045 rst=1 at a clock edge SHALL also drive a_ready, b_ready and busy to 0.
REQ-046 rst=1 SHALL take priority over every other input.
REQ-047 rst during CLEAR, FEED, DRAIN or HOLD SHALL abort the job and produce no result.
REQ-048 The next job after an abort SHALL still issue Clr before accumulating.

Verification
REQ-049 Basic job: len=3, A={1,2,3}, B={4,5,6}, inputs always valid -> exactly one Clr pulse, then 3 En pulses, then res_data=32 with res_valid rising 2 edges after the third consume.
REQ-050 Maximum job: len=255, all operands 255 -> res_data=16,581,375 (0xFD02FF).
REQ-051 Backpressure: a_valid=1 with b_valid=0 for 5 cycles, then both valid -> no consume and En=0 during those 5 cycles; the result is unchanged versus the no-stall run.
REQ-052 Ignored starts: start with len=0 in IDLE, and start during FEED -> busy unaffected, latched len unchanged, only one result produced.
REQ-053 Result hold and back-to-back: res_ready=0 for 10 cycles in HOLD -> res_data stable and res_valid held; a second job with len=2, A={7,1}, B={3,9} -> res_data=30, with Clr preceding its first En.
REQ-054 Reset mid-job: rst pulse in FEED after 2 of 4 pairs -> all outputs 0 on the next cycle; a following len=1 job with A=2, B=3 -> res_data=6.
